// File: rtl/bloom_filter_kway.sv
// -----------------------------------------------------------------------------
// bloom_filter_kway
//
// K-probe double-hashed bloom filter over 104-bit flow keys
// {ip_pro, src_port, dest_port}. The bit array holds 2^M_LOG2 bits.
// The filter makes one probe per cycle.
//
// Operations (op):
//   00 query, 01 insert, 10 clear, 11 query.
//
// Hashing:
//   The key is cut into M_LOG2-bit chunks. The last chunk is zero-extended.
//   h1 = XOR of all chunks
//   h2 = (sum of all chunks mod 2^M_LOG2) | 1
//   probe i reads bit (h1 + i*h2) mod 2^M_LOG2
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous reset, active low; clears the array and all state
//   in_valid     request strobe; a request is taken when in_valid & readyRecv
//   op           operation code, captured with the key at acceptance
//   ip_pro       {src_ip, dst_ip, protocol}; key bits [103:32]
//   src_port     key bits [31:16]
//   dest_port    key bits [15:0]
//   readyRecv    high only while idle
//   readyRes     one-cycle pulse; get_Result is valid during this pulse
//   get_Result   query: all K bits set; insert: all K bits already set; clear: 0
//   fill_count   number of array bits currently set
// -----------------------------------------------------------------------------
module bloom_filter_kway #(
   parameter int M_LOG2 = 10,
   parameter int K      = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [1:0]        op,
   input  logic [71:0]       ip_pro,
   input  logic [15:0]       src_port,
   input  logic [15:0]       dest_port,
   output logic              readyRecv,
   output logic              readyRes,
   output logic              get_Result,
   output logic [M_LOG2:0]   fill_count
);

   localparam int KEY_W   = 104;
   localparam int M_SIZE  = 1 << M_LOG2;
   localparam int N_CHUNK = (KEY_W + M_LOG2 - 1) / M_LOG2;
   localparam int PAD_W   = N_CHUNK * M_LOG2;
   localparam int PCNT_W  = (K > 1) ? $clog2(K) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HASH,
      S_PROBE,
      S_CLEAR,
      S_DONE
   } state_t;

   state_t               state_q, state_d;

   logic [KEY_W-1:0]     key_q;
   logic                 ins_q;
   logic [M_LOG2-1:0]    h2_q;
   logic [M_LOG2-1:0]    idx_q;      // loaded with h1, then stepped by h2
   logic [M_LOG2-1:0]    clr_addr_q;
   logic [PCNT_W-1:0]    probe_q;
   logic                 hit_q;
   logic [M_SIZE-1:0]    bits_q;
   logic [M_LOG2:0]      fill_q;

   logic [PAD_W-1:0]     key_pad;
   logic [M_LOG2-1:0]    h1_c, sum_c, h2_c;
   logic                 last_probe, last_clear, bit_rd;

   // Both hashes come from the captured key. The sum wraps naturally at
   // M_LOG2 bits, which gives the mod 2^M_LOG2.
   always_comb begin
      key_pad              = '0;
      key_pad[KEY_W-1:0]   = key_q;
      h1_c                 = '0;
      sum_c                = '0;
      for (int j = 0; j < N_CHUNK; j++) begin
         h1_c  = h1_c ^ key_pad[j*M_LOG2 +: M_LOG2];
         sum_c = sum_c + key_pad[j*M_LOG2 +: M_LOG2];
      end
      // An odd stride is coprime with 2^M_LOG2, so the K probes never collide.
      h2_c = sum_c | M_LOG2'(1);
   end

   assign last_probe = (probe_q == PCNT_W'(K - 1));
   assign last_clear = (clr_addr_q == '1);
   assign bit_rd     = bits_q[idx_q];
   assign fill_count = fill_q;

   // NOTE: every signal driven here gets a default first, so no path can leave it unassigned and infer a latch.
   always_comb begin
      state_d    = state_q;
      readyRecv  = 1'b0;
      readyRes   = 1'b0;
      get_Result = 1'b0;
      case (state_q)
         S_IDLE: begin
            readyRecv = 1'b1;
            if (in_valid) state_d = (op == 2'b10) ? S_CLEAR : S_HASH;
         end
         S_HASH:  state_d = S_PROBE;
         S_PROBE: if (last_probe) state_d = S_DONE;
         S_CLEAR: if (last_clear) state_d = S_DONE;
         S_DONE: begin
            readyRes   = 1'b1;
            get_Result = hit_q;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // NOTE: the bit array is a flop array and is reset. A reset must leave it empty, and partial inserts are discarded.
   always_ff @(posedge clk) begin
      if (!reset) begin
         key_q      <= '0;
         ins_q      <= 1'b0;
         h2_q       <= '0;
         idx_q      <= '0;
         clr_addr_q <= '0;
         probe_q    <= '0;
         hit_q      <= 1'b0;
         bits_q     <= '0;
         fill_q     <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  key_q      <= {ip_pro, src_port, dest_port};
                  ins_q      <= (op == 2'b01);
                  clr_addr_q <= '0;
                  hit_q      <= 1'b0;   // a clear reports 0
               end
            end
            S_HASH: begin
               idx_q   <= h1_c;
               h2_q    <= h2_c;
               probe_q <= '0;
               hit_q   <= 1'b1;
            end
            S_PROBE: begin
               // The result is the AND of the values read before any write.
               hit_q <= hit_q & bit_rd;
               if (ins_q && !bit_rd) begin
                  bits_q[idx_q] <= 1'b1;
                  fill_q        <= fill_q + (M_LOG2+1)'(1);
               end
               idx_q   <= idx_q + h2_q;
               probe_q <= probe_q + PCNT_W'(1);
            end
            S_CLEAR: begin
               bits_q[clr_addr_q] <= 1'b0;
               clr_addr_q         <= clr_addr_q + M_LOG2'(1);
               if (last_clear) fill_q <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bloom_filter_kway.sv
// -----------------------------------------------------------------------------
// tb_bloom_filter_kway
//
// Testbench for bloom_filter_kway with the default parameters.
//
// A behavioural model predicts what the DUT should output. It keeps an array of
// bits, a running count of set bits and the edge at which each operation should
// complete. A compare process checks the DUT against the model on every falling
// clock edge. Directed steps also pin literal results and latencies.
// -----------------------------------------------------------------------------
module tb_bloom_filter_kway;

   localparam int M_LOG2 = 10;
   localparam int K      = 3;
   localparam int MSZ    = 1 << M_LOG2;
   localparam int KEY_W  = 104;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              in_valid = 1'b0;
   logic [1:0]        op = 2'b00;
   logic [71:0]       ip_pro = '0;
   logic [15:0]       src_port = '0;
   logic [15:0]       dest_port = '0;
   logic              readyRecv;
   logic              readyRes;
   logic              get_Result;
   logic [M_LOG2:0]   fill_count;

   bloom_filter_kway #(.M_LOG2(M_LOG2), .K(K)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .op         (op),
      .ip_pro     (ip_pro),
      .src_port   (src_port),
      .dest_port  (dest_port),
      .readyRecv  (readyRecv),
      .readyRes   (readyRes),
      .get_Result (get_Result),
      .fill_count (fill_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic fail_timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out waiting for the DUT, expected a response", name);
   endtask

   // ---------------- behavioural model ----------------
   bit  model_arr [MSZ];
   int  model_fill = 0;
   bit  busy = 1'b0;
   int  due = 0;          // edge at which the DONE state is sampled
   bit  exp_result = 1'b0;
   int  exp_fill_done = 0;
   int  edge_n = 0;
   bit  armed = 1'b0;
   int  m_h1, m_h2, m_idx;
   bit  m_all;

   // The key is read bit by bit. Each chunk is built as an integer, so this
   // follows the arithmetic definition directly.
   function automatic void model_hash(input logic [KEY_W-1:0] key, output int h1, output int h2);
      int n_chunk;
      int sum;
      int c;
      int pos;
      n_chunk = (KEY_W + M_LOG2 - 1) / M_LOG2;
      sum = 0;
      h1  = 0;
      for (int j = 0; j < n_chunk; j++) begin
         c = 0;
         for (int b = 0; b < M_LOG2; b++) begin
            pos = j * M_LOG2 + b;
            if (pos < KEY_W && key[pos]) c += (1 << b);
         end
         h1  = h1 ^ c;
         sum = sum + c;
      end
      h2 = (sum % MSZ) | 1;
   endfunction

   always @(posedge clk) begin
      edge_n++;
      if (!reset) begin
         foreach (model_arr[i]) model_arr[i] = 1'b0;
         model_fill = 0;
         busy       = 1'b0;
         armed      = 1'b1;
      end else if (armed) begin
         if (busy) begin
            if (edge_n == due) busy = 1'b0;
         end else if (in_valid) begin
            if (op == 2'b10) begin
               foreach (model_arr[i]) model_arr[i] = 1'b0;
               model_fill = 0;
               exp_result = 1'b0;
               due        = edge_n + MSZ + 1;
            end else begin
               model_hash({ip_pro, src_port, dest_port}, m_h1, m_h2);
               m_all = 1'b1;
               for (int i = 0; i < K; i++) begin
                  m_idx = (m_h1 + i * m_h2) % MSZ;
                  if (!model_arr[m_idx]) m_all = 1'b0;
               end
               if (op == 2'b01) begin
                  for (int i = 0; i < K; i++) begin
                     m_idx = (m_h1 + i * m_h2) % MSZ;
                     if (!model_arr[m_idx]) begin
                        model_arr[m_idx] = 1'b1;
                        model_fill++;
                     end
                  end
               end
               exp_result = m_all;
               due        = edge_n + K + 2;
            end
            exp_fill_done = model_fill;
            busy          = 1'b1;
         end
      end
   end

   // Outputs are sampled on the falling edge, half a cycle after they settle.
   always @(negedge clk) begin
      if (armed) begin
         check("readyRecv", readyRecv, !busy);
         check("readyRes", readyRes, busy && (edge_n == due - 1));
         if (busy && (edge_n == due - 1)) begin
            check("get_Result", get_Result, exp_result);
            check("fill_at_done", fill_count, exp_fill_done);
         end
         if (!busy) check("fill_idle", fill_count, model_fill);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic scramble_key();
      ip_pro    = {$urandom(), $urandom(), 8'($urandom())};
      src_port  = 16'($urandom());
      dest_port = 16'($urandom());
   endtask

   task automatic wait_ready(input string tag);
      int n;
      n = 0;
      while (readyRecv !== 1'b1 && n < MSZ + 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= MSZ + 50) fail_timeout({tag, " ready"});
   endtask

   // Issues one request and waits for its readyRes pulse. If garble is set,
   // in_valid stays high with random keys while the request is in flight.
   // A negative exp_res or exp_fill skips that literal check.
   task automatic do_op(input string tag, input logic [71:0] ip, input logic [15:0] sp,
                        input logic [15:0] dp, input logic [1:0] o, input bit garble,
                        input int exp_lat, input int exp_res, input int exp_fill);
      int n;
      int t0;
      bit got;
      wait_ready(tag);
      ip_pro    = ip;
      src_port  = sp;
      dest_port = dp;
      op        = o;
      in_valid  = 1'b1;
      @(posedge clk); #1;
      t0 = edge_n;
      in_valid = garble;
      if (garble) begin
         scramble_key();
         op = 2'($urandom());
      end
      got = 1'b0;
      n   = 0;
      while (!got && n < MSZ + 50) begin
         @(negedge clk);
         if (readyRes === 1'b1) got = 1'b1;
         else begin
            @(posedge clk); #1;
            if (garble) begin
               scramble_key();
               op = 2'($urandom());
            end
            n++;
         end
      end
      if (!got) fail_timeout({tag, " result"});
      else begin
         check({tag, " latency"}, edge_n + 1 - t0, exp_lat);
         if (exp_res >= 0)  check({tag, " result"}, get_Result, exp_res);
         if (exp_fill >= 0) check({tag, " fill"}, fill_count, exp_fill);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   logic [71:0] pool_ip [6];
   logic [15:0] pool_sp [6];
   logic [15:0] pool_dp [6];

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int h1, h2, pulses, p, sel;
      logic [1:0] o;

      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;

      // Pin the model hash against hand-computed values.
      model_hash('0, h1, h2);
      check("model zero h1", h1, 0);
      check("model zero h2", h2, 1);
      model_hash({KEY_W{1'b1}}, h1, h2);
      check("model ones h1", h1, 15);
      check("model ones h2", h2, 5);
      model_hash({72'hF0_0000_0000_0000_0000, 16'h000F, 16'hE7F9}, h1, h2);
      check("model probe15 h1", h1, 15);
      check("model probe15 h2", h2, 1);

      // Directed sequence with literal expectations.
      do_op("q_first", 72'hC0A9011EC0A8011E1E, 16'd16538, 16'd37281, 2'b00, 1'b0, K + 2, 0, 0);
      do_op("ins_zero", '0, '0, '0, 2'b01, 1'b0, K + 2, 0, 3);
      do_op("ins_zero_again", '0, '0, '0, 2'b01, 1'b0, K + 2, 1, 3);
      do_op("q_zero", '0, '0, '0, 2'b00, 1'b0, K + 2, 1, 3);
      do_op("ins_ones", {72{1'b1}}, 16'hFFFF, 16'hFFFF, 2'b01, 1'b0, K + 2, 0, 6);
      do_op("q_probe15", 72'hF0_0000_0000_0000_0000, 16'h000F, 16'hE7F9, 2'b00, 1'b0, K + 2, 0, 6);
      do_op("clear", '0, '0, '0, 2'b10, 1'b0, MSZ + 1, 0, 0);
      do_op("q_zero_cleared", '0, '0, '0, 2'b00, 1'b0, K + 2, 0, 0);

      // Assert reset while the insert is in probe 1.
      wait_ready("rst_mid");
      ip_pro = '0; src_port = '0; dest_port = '0; op = 2'b01; in_valid = 1'b1;
      @(posedge clk); #1;        // accepted: state HASH
      in_valid = 1'b0;
      @(posedge clk); #1;        // state PROBE 0
      @(posedge clk); #1;        // state PROBE 1
      reset = 1'b0;
      @(posedge clk); #1;        // reset sampled
      check("rst_mid readyRecv", readyRecv, 1);
      check("rst_mid readyRes", readyRes, 0);
      check("rst_mid fill", fill_count, 0);
      reset = 1'b1;
      do_op("q_zero_after_reset", '0, '0, '0, 2'b00, 1'b0, K + 2, 0, 0);

      // in_valid stays high with changing keys. Only the key captured at acceptance counts.
      do_op("ins_garbled", '0, '0, '0, 2'b01, 1'b1, K + 2, 0, 3);
      do_op("q_after_garbled", '0, '0, '0, 2'b00, 1'b0, K + 2, 1, 3);

      // Back-to-back: with in_valid always high, requests are taken every K+3 cycles.
      wait_ready("b2b");
      ip_pro = '0; src_port = '0; dest_port = '0; op = 2'b00; in_valid = 1'b1;
      pulses = 0;
      for (int i = 0; i < 5 * (K + 3); i++) begin
         @(posedge clk); #1;
         scramble_key();
         op = {1'b0, 1'($urandom())};
         @(negedge clk);
         if (readyRes === 1'b1) pulses++;
      end
      in_valid = 1'b0;
      check("b2b pulse count", pulses, 5);

      // Random phase over a small key pool, so that repeated keys hit.
      pool_ip[0] = '0;         pool_sp[0] = '0;       pool_dp[0] = '0;
      pool_ip[1] = {72{1'b1}}; pool_sp[1] = 16'hFFFF; pool_dp[1] = 16'hFFFF;
      for (int i = 2; i < 6; i++) begin
         pool_ip[i] = {$urandom(), $urandom(), 8'($urandom())};
         pool_sp[i] = 16'($urandom());
         pool_dp[i] = 16'($urandom());
      end
      for (int r = 0; r < 80; r++) begin
         p   = $urandom_range(0, 5);
         sel = $urandom_range(0, 39);
         if (sel == 0)      o = 2'b10;
         else if (sel < 20) o = 2'b01;
         else if (sel < 36) o = 2'b00;
         else               o = 2'b11;
         do_op("rand", pool_ip[p], pool_sp[p], pool_dp[p], o, 1'($urandom()),
               (o == 2'b10) ? MSZ + 1 : K + 2, -1, -1);
      end

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
